// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle used between the FrontPanel-to-AXI-Lite master and
// the register bank.
//   aw*  write address channel     w*  write data channel
//   b*   write response channel    ar* read address channel
//   r*   read data channel
// Modports: master drives addresses/data/ready-for-response, slave drives
// the ready/valid/response signals.
interface axil_reg_bank_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank.
// NUM_RW read/write control registers followed by NUM_RO read-only status
// registers, 32 bits each, starting at BASE_ADDR. Accesses outside the map
// complete with SLVERR. One outstanding write and one outstanding read; the
// two channels are independent.
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   s_axil         AXI4-Lite slave port (axil_reg_bank_if.slave)
//   reg_out        R/W register contents, reg i at [32i+31:32i]
//   reg_wr_pulse   bit i high for one cycle after an OKAY write to reg i
//   reg_in         RO register sources, same packing as reg_out
module axil_reg_bank #(
  parameter int unsigned NUM_RW    = 8,
  parameter int unsigned NUM_RO    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] RW_RESET  = 32'h0000_0000
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axil_reg_bank_if.slave         s_axil,
  output logic [NUM_RW*32-1:0]   reg_out,
  output logic [NUM_RW-1:0]      reg_wr_pulse,
  input  logic [NUM_RO*32-1:0]   reg_in
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    TGT_RW,
    TGT_RO,
    TGT_OOM
  } tgt_e;

  // Word index relative to the bank base; byte-lane bits are dropped.
  function automatic logic [31:0] addr_idx(input logic [31:0] addr);
    return (addr - BASE_ADDR) >> 2;
  endfunction

  function automatic tgt_e addr_tgt(input logic [31:0] addr);
    if (addr < BASE_ADDR)                    return TGT_OOM;
    else if (addr_idx(addr) < NUM_RW)          return TGT_RW;
    else if (addr_idx(addr) < NUM_RW + NUM_RO) return TGT_RO;
    return TGT_OOM;
  endfunction

  logic [31:0] regs [NUM_RW];

  // Write-path state
  logic        aw_full, w_full;
  logic        awready_q, wready_q;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  // Read-path state
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_hs, w_hs, b_hs, commit;
  logic        aw_full_nxt, w_full_nxt;
  logic [31:0] wr_idx;
  tgt_e        wr_tgt;

  logic        ar_hs, r_hs, rvalid_nxt;
  logic [31:0] rd_idx;
  tgt_e        rd_tgt;
  logic [31:0] rd_data;

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs[g];
  end

  // Ready flags are registered copies of the next holding state so they
  // read 0 in reset and rise on the first edge after release.
  always_comb begin
    aw_hs       = s_axil.awvalid & awready_q;
    w_hs        = s_axil.wvalid & wready_q;
    b_hs        = bvalid_q & s_axil.bready;
    commit      = aw_full & w_full & ~bvalid_q;
    aw_full_nxt = b_hs ? 1'b0 : (aw_full | aw_hs);
    w_full_nxt  = b_hs ? 1'b0 : (w_full | w_hs);
    wr_idx      = addr_idx(aw_addr_q);
    wr_tgt      = addr_tgt(aw_addr_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_RW; i++) regs[i] <= RW_RESET;
    end else begin
      aw_full      <= aw_full_nxt;
      w_full       <= w_full_nxt;
      awready_q    <= ~aw_full_nxt;
      wready_q     <= ~w_full_nxt;
      reg_wr_pulse <= '0;
      if (aw_hs) aw_addr_q <= s_axil.awaddr;
      if (w_hs) begin
        w_data_q <= s_axil.wdata;
        w_strb_q <= s_axil.wstrb;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_tgt == TGT_RW) ? RESP_OKAY : RESP_SLVERR;
        if (wr_tgt == TGT_RW) begin
          for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (wr_idx == i) begin
              reg_wr_pulse[i] <= 1'b1;
              for (int unsigned b = 0; b < 4; b++) begin
                if (w_strb_q[b]) regs[i][8*b +: 8] <= w_data_q[8*b +: 8];
              end
            end
          end
        end
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read data mux works on the live register array, so a read landing on
  // the same edge as a write commit returns the pre-write value.
  always_comb begin
    ar_hs      = s_axil.arvalid & arready_q;
    r_hs       = rvalid_q & s_axil.rready;
    rvalid_nxt = ar_hs ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);
    rd_idx     = addr_idx(s_axil.araddr);
    rd_tgt     = addr_tgt(s_axil.araddr);
    rd_data    = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (rd_tgt == TGT_RW && rd_idx == i) rd_data = regs[i];
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (rd_tgt == TGT_RO && rd_idx == NUM_RW + j) rd_data = reg_in[32*j +: 32];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rvalid_q  <= rvalid_nxt;
      arready_q <= ~rvalid_nxt;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= (rd_tgt == TGT_OOM) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
module tb_axil_reg_bank;

  logic         aclk;
  logic         aresetn;
  logic [255:0] reg_out;
  logic [7:0]   reg_wr_pulse;
  logic [255:0] reg_in;

  axil_reg_bank_if bus();

  axil_reg_bank #(
    .NUM_RW   (8),
    .NUM_RO   (8),
    .BASE_ADDR(32'h0000_0000),
    .RW_RESET (32'h0000_0000)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axil      (bus.slave),
    .reg_out     (reg_out),
    .reg_wr_pulse(reg_wr_pulse),
    .reg_in      (reg_in)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] data;   // read: rdata; OKAY write: new register value
    logic [7:0]  pulse;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] model [8];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] packed_model();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[32*i +: 32] = model[i];
    return p;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [7:0] pulse);
    logic aw_pend, w_pend, a, w;
    int   cnt;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; cnt = 0;
    while ((aw_pend || w_pend) && cnt < 20) begin
      a = bus.awvalid & bus.awready;
      w = bus.wvalid & bus.wready;
      tick();
      if (a) begin bus.awvalid = 1'b0; aw_pend = 1'b0; end
      if (w) begin bus.wvalid = 1'b0; w_pend = 1'b0; end
      cnt++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    cnt = 0;
    while (!bus.bvalid && cnt < 20) begin tick(); cnt++; end
    check("wr_bvalid_wait", {255'd0, bus.bvalid}, 256'd1);
    resp  = bus.bresp;
    pulse = reg_wr_pulse;
    tick();
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cnt;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    cnt = 0;
    while (!bus.arready && cnt < 20) begin tick(); cnt++; end
    tick();
    bus.arvalid = 1'b0;
    check("rd_rvalid", {255'd0, bus.rvalid}, 256'd1);
    data = bus.rdata;
    resp = bus.rresp;
    tick();
  endtask

  initial begin
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] data;
    int          bad;

    vecs[0]  = '{1'b1, 32'h04, 32'hA5A5_5A5A, 4'b0101, 2'b00, 32'h00A5_005A, 8'h02};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,         4'b0000, 2'b00, 32'h00A5_005A, 8'h00};
    vecs[2]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 4'b1000, 2'b00, 32'hFFA5_005A, 8'h02};
    vecs[3]  = '{1'b1, 32'h00, 32'hDEAD_BEEF, 4'b1111, 2'b00, 32'hDEAD_BEEF, 8'h01};
    vecs[4]  = '{1'b1, 32'h1C, 32'h1234_5678, 4'b0000, 2'b00, 32'h0000_0000, 8'h80};
    vecs[5]  = '{1'b1, 32'h1D, 32'hCAFE_F00D, 4'b1111, 2'b00, 32'hCAFE_F00D, 8'h80};
    vecs[6]  = '{1'b0, 32'h1C, 32'h0,         4'b0000, 2'b00, 32'hCAFE_F00D, 8'h00};
    vecs[7]  = '{1'b0, 32'h20, 32'h0,         4'b0000, 2'b00, 32'h1234_5678, 8'h00};
    vecs[8]  = '{1'b0, 32'h3C, 32'h0,         4'b0000, 2'b00, 32'hC0DE_0007, 8'h00};
    vecs[9]  = '{1'b1, 32'h20, 32'hFFFF_FFFF, 4'b1111, 2'b10, 32'h0,         8'h00};
    vecs[10] = '{1'b0, 32'h40, 32'h0,         4'b0000, 2'b10, 32'h0,         8'h00};
    vecs[11] = '{1'b1, 32'h7C, 32'hFFFF_FFFF, 4'b1111, 2'b10, 32'h0,         8'h00};
    vecs[12] = '{1'b0, 32'h00, 32'h0,         4'b0000, 2'b00, 32'hDEAD_BEEF, 8'h00};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,  4'b0000, 2'b10, 32'h0,         8'h00};

    reg_in[31:0] = 32'h1234_5678;
    for (int j = 1; j < 8; j++) reg_in[32*j +: 32] = 32'hC0DE_0000 | j;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    aresetn = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_readys", {253'd0, bus.awready, bus.wready, bus.arready}, 256'd0);
    check("rst_valids", {254'd0, bus.bvalid, bus.rvalid}, 256'd0);
    check("rst_pulse", {248'd0, reg_wr_pulse}, 256'd0);
    aresetn = 1'b1;
    tick();
    check("post_rst_readys", {253'd0, bus.awready, bus.wready, bus.arready}, 256'd7);
    check("post_rst_reg_out", reg_out, 256'd0);

    // Table-driven accesses
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].is_wr) begin
        do_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb, resp, pulse);
        if (vecs[v].resp == 2'b00) model[vecs[v].addr[4:2]] = vecs[v].data;
        check($sformatf("v%0d_bresp", v), {254'd0, resp}, {254'd0, vecs[v].resp});
        check($sformatf("v%0d_pulse", v), {248'd0, pulse}, {248'd0, vecs[v].pulse});
        check($sformatf("v%0d_reg_out", v), reg_out, packed_model());
        check($sformatf("v%0d_pulse_gone", v), {248'd0, reg_wr_pulse}, 256'd0);
      end else begin
        do_read(vecs[v].addr, data, resp);
        check($sformatf("v%0d_rresp", v), {254'd0, resp}, {254'd0, vecs[v].resp});
        check($sformatf("v%0d_rdata", v), {224'd0, data}, {224'd0, vecs[v].data});
      end
    end

    // W leads AW by 3 cycles; bready held low for 5 cycles
    bus.bready = 1'b0;
    bus.wdata = 32'h1122_3344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("hold_wready_low", {255'd0, bus.wready}, 256'd0);
    repeat (2) tick();
    bus.awaddr = 32'h08; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    tick();
    model[2] = 32'h1122_3344;
    check("hold_bvalid", {255'd0, bus.bvalid}, 256'd1);
    check("hold_pulse", {248'd0, reg_wr_pulse}, 256'h04);
    bad = 0;
    repeat (5) begin
      tick();
      if (!bus.bvalid || bus.bresp != 2'b00 || bus.awready || bus.wready || reg_wr_pulse != 8'h00) bad++;
    end
    check("hold_stable", bad, 0);
    bus.bready = 1'b1;
    tick();
    check("hold_release", {253'd0, bus.bvalid, bus.awready, bus.wready}, 256'd3);
    check("hold_reg_out", reg_out, packed_model());

    // Read and write commit to reg3 on the same edge: read sees old value
    bus.awaddr = 32'h0C; bus.wdata = 32'h55AA_55AA; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    model[3] = 32'h55AA_55AA;
    check("same_edge_valids", {254'd0, bus.rvalid, bus.bvalid}, 256'd3);
    check("same_edge_rdata", {224'd0, bus.rdata}, 256'd0);
    check("same_edge_reg_out", reg_out, packed_model());
    tick();
    check("same_edge_done", {254'd0, bus.rvalid, bus.bvalid}, 256'd0);

    // Read data held while rready is low
    bus.rready = 1'b0;
    bus.araddr = 32'h24; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    bad = 0;
    repeat (3) begin
      tick();
      if (!bus.rvalid || bus.rdata != 32'hC0DE_0001 || bus.rresp != 2'b00 || bus.arready) bad++;
    end
    check("rhold_stable", bad, 0);
    bus.rready = 1'b1;
    tick();
    check("rhold_release", {254'd0, bus.rvalid, bus.arready}, 256'd1);

    // Reset after AW accepted, before W
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    aresetn = 1'b0;
    #2;
    check("midrst_readys", {253'd0, bus.awready, bus.wready, bus.arready}, 256'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    bad = 0;
    repeat (5) begin
      tick();
      if (bus.bvalid) bad++;
    end
    check("midrst_no_bvalid", bad, 0);
    check("midrst_reg_out", reg_out, packed_model());
    do_write(32'h14, 32'h0BAD_F00D, 4'hF, resp, pulse);
    model[5] = 32'h0BAD_F00D;
    check("midrst_bresp", {254'd0, resp}, 256'd0);
    check("midrst_pulse", {248'd0, pulse}, 256'h20);
    check("midrst_write", reg_out, packed_model());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
